// File: rtl/pls_pkg.sv
// Shared types and constants for the switch-line pulse driver.
package pls_pkg;

  localparam int TLEN_W = 16;

  // Time-unit encodings; 2'b11 is treated as microseconds.
  localparam logic [1:0] TU_US = 2'b00;
  localparam logic [1:0] TU_MS = 2'b01;
  localparam logic [1:0] TU_S  = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOW    = 3'd1,
    GAP    = 3'd2,
    DONE   = 3'd3,
    BOUNCE = 3'd4
  } pls_state_e;

endpackage

// File: rtl/pls_drv_if.sv
// Sequencer-to-driver handshake and switch-line bundle.
interface pls_drv_if;
  import pls_pkg::*;

  logic              en;
  logic              start;
  logic [1:0]        tunit;
  logic [TLEN_W-1:0] tlen;
  logic              busy;
  logic              done;
  logic              s_out;

  modport master (output en, start, tunit, tlen, input busy, done, s_out);
  modport slave  (input en, start, tunit, tlen, output busy, done, s_out);

endinterface

// File: rtl/pls_drv_tick_gen.sv
// Cascaded us/ms/s prescaler. A synchronous clear restarts all three stages
// so that a timed interval always begins on a full unit boundary.
module tick_gen import pls_pkg::*; #(
  parameter int CNT1US = 107,
  parameter int CNT1MS = 1000,
  parameter int CNT1S  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [1:0] tunit,
  output logic       tick_us,
  output logic       tick_ms,
  output logic       tick_s,
  output logic       tick_unit
);

  localparam int US_W = $clog2(CNT1US + 1);
  localparam int MS_W = $clog2(CNT1MS + 1);
  localparam int S_W  = $clog2(CNT1S + 1);

  logic [US_W-1:0] us_cnt;
  logic [MS_W-1:0] ms_cnt;
  logic [S_W-1:0]  s_cnt;

  assign tick_us = (us_cnt == US_W'(CNT1US - 1));
  assign tick_ms = tick_us && (ms_cnt == MS_W'(CNT1MS - 1));
  assign tick_s  = tick_ms && (s_cnt == S_W'(CNT1S - 1));

  // Clock-cycle prescaler producing the 1 us tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          us_cnt <= '0;
    else if (clr)     us_cnt <= '0;
    else if (tick_us) us_cnt <= '0;
    else              us_cnt <= us_cnt + US_W'(1);
  end

  // Microsecond counter producing the 1 ms tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ms_cnt <= '0;
    else if (clr)     ms_cnt <= '0;
    else if (tick_ms) ms_cnt <= '0;
    else if (tick_us) ms_cnt <= ms_cnt + MS_W'(1);
  end

  // Millisecond counter producing the 1 s tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          s_cnt <= '0;
    else if (clr)     s_cnt <= '0;
    else if (tick_s)  s_cnt <= '0;
    else if (tick_ms) s_cnt <= s_cnt + S_W'(1);
  end

  // Pick the tick matching the requested pulse unit.
  always_comb begin
    tick_unit = tick_us;
    case (tunit)
      TU_MS:   tick_unit = tick_ms;
      TU_S:    tick_unit = tick_s;
      default: tick_unit = tick_us;
    endcase
  end

endmodule

// File: rtl/pls_drv.sv
// Switch-line pulse driver: active-low pulse of tlen units, then a fixed
// recovery gap, handshaken through start/busy/done.
// Optional macro PLS_BOUNCE_EN adds a contact-chatter burst before the pulse.
//
// state  | meaning
// IDLE   | line high, waiting for start with en=1
// BOUNCE | chatter burst, 1 us low / 1 us high per pulse (PLS_BOUNCE_EN only)
// LOW    | line driven low for tlen units
// GAP    | line high for GAP_US microseconds of recovery
// DONE   | one-cycle done strobe, busy drops on exit
module pls_drv import pls_pkg::*; #(
  parameter int CNT1US   = 107,
  parameter int CNT1MS   = 1000,
  parameter int CNT1S    = 1000,
`ifdef PLS_BOUNCE_EN
  parameter int BOUNCE_N = 3,
`endif
  parameter int GAP_US   = 10
) (
  input logic     clk,
  input logic     rst,
  pls_drv_if.slave bus
);

  localparam int GAP_W = $clog2(GAP_US + 1);
`ifdef PLS_BOUNCE_EN
  localparam int BNC_W = $clog2(2 * BOUNCE_N + 1);
  logic [BNC_W-1:0] bnc_cnt;
  logic             bnc_end;
`endif

  pls_state_e        state;
  logic [1:0]        tunit_q;
  logic [TLEN_W-1:0] tlen_q;
  logic [TLEN_W-1:0] unit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              tick_us, tick_ms, tick_s, tick_unit, tick_clr;
  logic              accept, low_end, gap_end;
  logic              unused_ticks;

  assign unused_ticks = tick_ms ^ tick_s;

  tick_gen #(.CNT1US(CNT1US), .CNT1MS(CNT1MS), .CNT1S(CNT1S)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clr      (tick_clr),
    .tunit    (tunit_q),
    .tick_us  (tick_us),
    .tick_ms  (tick_ms),
    .tick_s   (tick_s),
    .tick_unit(tick_unit)
  );

  // tlen_q is never zero in LOW, so tlen_q-1 cannot wrap; 16'hFFFF still fits.
  assign accept  = (state == IDLE) && bus.start && bus.en;
  assign low_end = tick_unit && (unit_cnt == tlen_q - TLEN_W'(1));
  assign gap_end = tick_us && (gap_cnt == '0);
`ifdef PLS_BOUNCE_EN
  assign bnc_end = tick_us && (bnc_cnt == '0);
`endif

  // Restart the prescaler on every state change so each interval is exact.
  always_comb begin
    tick_clr = 1'b0;
    case (state)
      IDLE:    tick_clr = accept;
      LOW:     tick_clr = !bus.en || low_end;
      GAP:     tick_clr = gap_end;
`ifdef PLS_BOUNCE_EN
      BOUNCE:  tick_clr = !bus.en || bnc_end;
`endif
      default: tick_clr = 1'b0;
    endcase
  end

  // Sequencing FSM with registered line and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bus.s_out <= 1'b1;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      tunit_q   <= TU_US;
      tlen_q    <= '0;
      unit_cnt  <= '0;
      gap_cnt   <= '0;
`ifdef PLS_BOUNCE_EN
      bnc_cnt   <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tunit_q  <= bus.tunit;
            tlen_q   <= bus.tlen;
            unit_cnt <= '0;
            bus.busy <= 1'b1;
            if (bus.tlen == '0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              bus.s_out <= 1'b0;
`ifdef PLS_BOUNCE_EN
              state   <= BOUNCE;
              bnc_cnt <= BNC_W'(2 * BOUNCE_N - 1);
`else
              state   <= LOW;
`endif
            end
          end
        end
`ifdef PLS_BOUNCE_EN
        // Each us tick flips the line; the last half-period hands over to LOW.
        BOUNCE: begin
          if (!bus.en) begin
            bus.s_out <= 1'b1;
            gap_cnt   <= GAP_W'(GAP_US - 1);
            state     <= GAP;
          end else if (bnc_end) begin
            bus.s_out <= 1'b0;
            state     <= LOW;
          end else if (tick_us) begin
            bnc_cnt   <= bnc_cnt - BNC_W'(1);
            bus.s_out <= ~bus.s_out;
          end
        end
`endif
        LOW: begin
          if (!bus.en || low_end) begin
            bus.s_out <= 1'b1;
            gap_cnt   <= GAP_W'(GAP_US - 1);
            state     <= GAP;
          end else if (tick_unit) begin
            unit_cnt <= unit_cnt + TLEN_W'(1);
          end
        end
        GAP: begin
          if (gap_end) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else if (tick_us) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pls_drv.sv
// Directed bench for pls_drv with CNT1US=4, CNT1MS=3, CNT1S=2, GAP_US=10.
// Observation index k counts cycles after the accepting edge (sampled 1 ns
// after each rising edge), so k=0 shows the outputs set by the accepting edge.
module tb_pls_drv;
  import pls_pkg::*;

  logic clk = 1'b0;
  logic rst;

  pls_drv_if bus();

  pls_drv #(.CNT1US(4), .CNT1MS(3), .CNT1S(2), .GAP_US(10)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int low_cnt, first_low, last_low, done_k, done_cnt, busy_k, early_drop;
  bit timeout;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start, then follow the transaction until busy drops.
  // Optionally drop en after observation abort_k, or pulse a second start
  // (with a different tlen) after observation restart_k.
  task automatic run(input logic [1:0] tu, input logic [15:0] tl,
                     input int abort_k, input int restart_k,
                     input logic [15:0] restart_tl);
    bus.tunit = tu;
    bus.tlen  = tl;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    low_cnt = 0; first_low = -1; last_low = -1; done_k = -1; done_cnt = 0;
    busy_k = -1; early_drop = 0; timeout = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if (bus.s_out === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = k;
        last_low = k;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (bus.busy !== 1'b1 && done_k < 0) early_drop = 1;
      if (k == restart_k + 1) bus.start = 1'b0;
      if (k == restart_k) begin
        bus.start = 1'b1;
        bus.tlen  = restart_tl;
      end
      if (k == abort_k) bus.en = 1'b0;
      if (bus.busy === 1'b0 && done_k >= 0) begin
        busy_k  = k;
        timeout = 1'b0;
        break;
      end
      tick();
    end
    bus.start = 1'b0;
    bus.en    = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1; bus.start = 1'b0; bus.tunit = TU_US; bus.tlen = '0;
    tick(); tick();
    n_cmp++; if (bus.s_out !== 1'b1) begin n_bad++; $display("FAIL reset_s_out: got %b want 1", bus.s_out); end
    n_cmp++; if (bus.busy !== 1'b0)  begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0)  begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    rst = 1'b0;
    tick();
    n_cmp++; if (bus.s_out !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset: got s_out=%b busy=%b want 1/0", bus.s_out, bus.busy); end
  endtask

  // tlen=5 us: 20 cycles low, 40-cycle gap, done at k=60, busy low from k=61.
  task automatic test_basic();
    run(TU_US, 16'd5, -1, -1, 16'd0);
    n_cmp++; if (timeout)        begin n_bad++; $display("FAIL basic_timeout: busy never dropped"); end
    n_cmp++; if (low_cnt != 20)  begin n_bad++; $display("FAIL basic_low_len: got %0d want 20", low_cnt); end
    n_cmp++; if (first_low != 0 || last_low != 19) begin n_bad++; $display("FAIL basic_low_window: got %0d..%0d want 0..19", first_low, last_low); end
    n_cmp++; if (done_k != 60)   begin n_bad++; $display("FAIL basic_done_at: got %0d want 60", done_k); end
    n_cmp++; if (done_cnt != 1)  begin n_bad++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++; if (busy_k != 61)   begin n_bad++; $display("FAIL basic_busy_drop: got %0d want 61", busy_k); end
    n_cmp++; if (early_drop != 0) begin n_bad++; $display("FAIL basic_busy_hold: got early drop want none"); end
  endtask

  // ms: 2*12=24 low; s: 1*24=24 low; tunit=11 behaves as us: 2*4=8 low.
  task automatic test_units();
    run(TU_MS, 16'd2, -1, -1, 16'd0);
    n_cmp++; if (low_cnt != 24 || timeout) begin n_bad++; $display("FAIL ms_low_len: got %0d want 24", low_cnt); end
    n_cmp++; if (done_k != 64) begin n_bad++; $display("FAIL ms_done_at: got %0d want 64", done_k); end
    run(TU_S, 16'd1, -1, -1, 16'd0);
    n_cmp++; if (low_cnt != 24 || timeout) begin n_bad++; $display("FAIL s_low_len: got %0d want 24", low_cnt); end
    n_cmp++; if (done_k != 64) begin n_bad++; $display("FAIL s_done_at: got %0d want 64", done_k); end
    run(2'b11, 16'd2, -1, -1, 16'd0);
    n_cmp++; if (low_cnt != 8 || timeout) begin n_bad++; $display("FAIL tu11_low_len: got %0d want 8", low_cnt); end
    n_cmp++; if (done_k != 48) begin n_bad++; $display("FAIL tu11_done_at: got %0d want 48", done_k); end
  endtask

  task automatic test_zero_len();
    run(TU_US, 16'd0, -1, -1, 16'd0);
    n_cmp++; if (low_cnt != 0)  begin n_bad++; $display("FAIL zero_low: got %0d want 0", low_cnt); end
    n_cmp++; if (done_k != 0 || done_cnt != 1) begin n_bad++; $display("FAIL zero_done: got at %0d x%0d want at 0 x1", done_k, done_cnt); end
    n_cmp++; if (busy_k != 1 || timeout) begin n_bad++; $display("FAIL zero_busy_drop: got %0d want 1", busy_k); end
  endtask

  // Second start with tlen=9 during LOW must not change the pulse or add a done.
  task automatic test_busy_reject();
    run(TU_US, 16'd5, -1, 5, 16'd9);
    n_cmp++; if (low_cnt != 20) begin n_bad++; $display("FAIL reject_low_len: got %0d want 20", low_cnt); end
    n_cmp++; if (done_cnt != 1 || busy_k != 61) begin n_bad++; $display("FAIL reject_done: got x%0d drop %0d want x1 drop 61", done_cnt, busy_k); end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (bus.busy !== 1'b0 || bus.s_out !== 1'b1) begin n_bad++; $display("FAIL reject_requeue: got busy=%b s_out=%b want 0/1", bus.busy, bus.s_out); end
  endtask

  // Start in the DONE cycle is dropped; start in the first IDLE cycle is taken.
  task automatic test_back_to_back();
    run(TU_US, 16'd5, -1, 60, 16'd3);
    n_cmp++; if (busy_k != 61) begin n_bad++; $display("FAIL done_start_drop: got %0d want 61", busy_k); end
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL done_start_ignored: got busy=%b want 0", bus.busy); end
    run(TU_US, 16'd2, -1, -1, 16'd0);
    n_cmp++; if (low_cnt != 8 || first_low != 0) begin n_bad++; $display("FAIL b2b_first: got len %0d at %0d want 8 at 0", low_cnt, first_low); end
    run(TU_US, 16'd1, -1, -1, 16'd0);
    n_cmp++; if (low_cnt != 4 || done_k != 44) begin n_bad++; $display("FAIL b2b_second: got len %0d done %0d want 4/44", low_cnt, done_k); end
  endtask

  // en sampled low at the 10th edge of a 5 us pulse: 10 low cycles, full gap.
  task automatic test_abort();
    run(TU_US, 16'd5, 9, -1, 16'd0);
    n_cmp++; if (low_cnt != 10 || last_low != 9) begin n_bad++; $display("FAIL abort_low: got %0d ending %0d want 10 ending 9", low_cnt, last_low); end
    n_cmp++; if (done_k != 50 || busy_k != 51) begin n_bad++; $display("FAIL abort_done: got %0d/%0d want 50/51", done_k, busy_k); end
    n_cmp++; if (early_drop != 0 || timeout) begin n_bad++; $display("FAIL abort_busy_hold: got early drop want none"); end
  endtask

  task automatic test_reset_mid();
    bus.tunit = TU_US; bus.tlen = 16'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (bus.s_out !== 1'b0) begin n_bad++; $display("FAIL rstmid_pre: got s_out=%b want 0", bus.s_out); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.s_out !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_async: got s_out=%b busy=%b want 1/0", bus.s_out, bus.busy); end
    #2 rst = 1'b0;
    tick();
    run(TU_US, 16'd3, -1, -1, 16'd0);
    n_cmp++; if (low_cnt != 12 || done_k != 52 || timeout) begin n_bad++; $display("FAIL rstmid_after: got len %0d done %0d want 12/52", low_cnt, done_k); end
  endtask

`ifdef PLS_BOUNCE_EN
  // Three 4+4 chatter pairs (k 0..23), then the 20-cycle main pulse (k 24..43).
  task automatic test_bounce();
    int errs;
    logic exp_s;
    errs = 0;
    bus.tunit = TU_US; bus.tlen = 16'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k <= 44; k++) begin
      if (k < 24)      exp_s = ((k / 4) % 2 == 1);
      else if (k < 44) exp_s = 1'b0;
      else             exp_s = 1'b1;
      if (bus.s_out !== exp_s) errs++;
      if (k < 44) tick();
    end
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL bounce_pattern: got %0d wrong cycles want 0", errs); end
    for (int i = 0; i < 200 && bus.busy === 1'b1; i++) tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL bounce_finish: got busy=%b want 0", bus.busy); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef PLS_BOUNCE_EN
    test_bounce();
`else
    test_basic();
    test_units();
    test_zero_len();
    test_busy_reject();
    test_back_to_back();
    test_abort();
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
